hamming_tx_encoder: RTL and testbench

//   Transmit side of the Hamming(11,7) link. Accepts 7-bit data words on a

---
 rtl/hamming_tx_encoder.sv | 164 ++++++++++++++++
 tb/tb_hamming_tx_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_tx_encoder.sv
// hamming_tx_encoder
//   Transmit side of the Hamming(11,7) link. Accepts a 7-bit word on a
//   valid/ready handshake, encodes it into an 11-bit even-parity codeword
//   (optionally inverting one position), and serialises it onto a single,
//   idle-high wire as: start bit (0), cw[0]..cw[10], stop bit (1).
//   Every bit is held for BIT_CYCLES clocks.
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    data word d[6:0]
//   in_valid   in_data/err_pos valid
//   in_ready   encoder can accept a word
//   err_pos    1..11 inverts codeword position err_pos; other values inject nothing
//   tx         serial line, idle high
//   busy       frame in progress
//   cw_out     last encoded codeword (after injection), for loopback
//   cw_valid   1-cycle pulse when cw_out updates
//   frame_done 1-cycle pulse in the last clock of the stop bit
module hamming_tx_encoder #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  err_pos,
  output logic        tx,
  output logic        busy,
  output logic [10:0] cw_out,
  output logic        cw_valid,
  output logic        frame_done
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // A 1-clock bit still needs a 1-bit counter to keep the vectors legal.
  localparam int unsigned CycW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(BIT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [3:0]      bit_q, bit_d;
  logic [10:0]     cw_q;
  logic            cw_valid_q;
  logic            ready_q;

  logic [10:0]     enc;
  logic [10:0]     inj;
  logic            accept;
  logic            cyc_last;

  // Codeword generation: data at positions 3,5,6,7,9,10,11; parity at 1,2,4,8.
  always_comb begin
    enc     = '0;
    enc[2]  = in_data[0];
    enc[4]  = in_data[1];
    enc[5]  = in_data[2];
    enc[6]  = in_data[3];
    enc[8]  = in_data[4];
    enc[9]  = in_data[5];
    enc[10] = in_data[6];
    enc[0]  = in_data[0] ^ in_data[1] ^ in_data[3] ^ in_data[4] ^ in_data[6];
    enc[1]  = in_data[0] ^ in_data[2] ^ in_data[3] ^ in_data[5] ^ in_data[6];
    enc[3]  = in_data[1] ^ in_data[2] ^ in_data[3];
    enc[7]  = in_data[4] ^ in_data[5] ^ in_data[6];
    inj     = '0;
    if ((err_pos != 4'd0) && (err_pos <= 4'd11)) begin
      inj = 11'd1 << (err_pos - 4'd1);
    end
  end

  // ready_q is only ever set while idle, so it alone qualifies acceptance.
  assign accept   = in_valid && ready_q;
  assign cyc_last = (cyc_q == CycLast);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      bit_q      <= '0;
      cw_q       <= '0;
      cw_valid_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      cw_valid_q <= accept;
      // Registered from the next state so ready appears one clock after reset
      // release and one clock after frame_done.
      ready_q    <= (state_d == StIdle);
      if (accept) begin
        cw_q <= enc ^ inj;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StStart;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (cyc_last) begin
          state_d = StData;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StData: begin
        if (cyc_last) begin
          cyc_d = '0;
          if (bit_q == 4'd10) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StStop: begin
        if (cyc_last) begin
          state_d = StIdle;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
    endcase
  end

  // Outputs: tx decodes from state so an async reset forces the line high at once.
  always_comb begin
    tx         = 1'b1;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle:  tx = 1'b1;
      StStart: tx = 1'b0;
      StData:  tx = cw_q[bit_q];
      StStop: begin
        tx         = 1'b1;
        frame_done = cyc_last;
      end
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign in_ready = ready_q;
  assign cw_out   = cw_q;
  assign cw_valid = cw_valid_q;

endmodule

// File: tb/tb_hamming_tx_encoder.sv
module tb_hamming_tx_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  in_data;
  logic [3:0]  err_pos;
  logic        valid_a, valid_b;
  logic        rdy_a, rdy_b, tx_a, tx_b, busy_a, busy_b;
  logic [10:0] cw_a, cw_b;
  logic        cwv_a, cwv_b, fd_a, fd_b;

  int vectors = 0;
  int miscompares = 0;
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];

  always #5 clk = ~clk;

  hamming_tx_encoder #(.BIT_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_a), .in_ready(rdy_a),
    .err_pos(err_pos), .tx(tx_a), .busy(busy_a), .cw_out(cw_a), .cw_valid(cwv_a),
    .frame_done(fd_a)
  );

  hamming_tx_encoder #(.BIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_b), .in_ready(rdy_b),
    .err_pos(err_pos), .tx(tx_b), .busy(busy_b), .cw_out(cw_b), .cw_valid(cwv_b),
    .frame_done(fd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: each parity bit at position 2^i covers every position
  // whose index has bit i set.
  function automatic logic [10:0] enc(input logic [6:0] d, input logic [3:0] e);
    logic [10:0] c;
    int dpos[7] = '{3, 5, 6, 7, 9, 10, 11};
    c = '0;
    for (int j = 0; j < 7; j++) c[dpos[j]-1] = d[j];
    for (int i = 0; i < 4; i++) begin
      logic p;
      p = 1'b0;
      for (int pos = 1; pos <= 11; pos++)
        if (((pos >> i) & 1) == 1 && pos != (1 << i)) p = p ^ c[pos-1];
      c[(1 << i) - 1] = p;
    end
    if (e >= 1 && e <= 11) c[e-1] = ~c[e-1];
    return c;
  endfunction

  function automatic int syndrome(input logic [10:0] c);
    int s = 0;
    for (int pos = 1; pos <= 11; pos++) if (c[pos-1]) s = s ^ pos;
    return s;
  endfunction

  function automatic logic [6:0] correct(input logic [10:0] c);
    logic [10:0] f;
    int s;
    f = c;
    s = syndrome(c);
    if (s >= 1 && s <= 11) f[s-1] = ~f[s-1];
    return {f[10], f[9], f[8], f[6], f[5], f[4], f[2]};
  endfunction

  // {tx, busy, in_ready, frame_done, cw_valid}
  function automatic logic [4:0] outs(input bit sel);
    return sel ? {tx_b, busy_b, rdy_b, fd_b, cwv_b} : {tx_a, busy_a, rdy_a, fd_a, cwv_a};
  endfunction

  // Scoreboard: codewords are pushed at drive time and popped on cw_valid.
  always @(negedge clk) begin
    if (!rst && cwv_a) begin
      if (q_a.size() == 0) chk("sb_a_unexpected", 1, 0);
      else chk("sb_a_cw", cw_a, q_a.pop_front());
    end
    if (!rst && cwv_b) begin
      if (q_b.size() == 0) chk("sb_b_unexpected", 1, 0);
      else chk("sb_b_cw", cw_b, q_b.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge of the clock after acceptance.
  task automatic accept(input bit sel, input logic [6:0] d, input logic [3:0] e,
                        output int waited);
    logic [4:0] o;
    in_data = d;
    err_pos = e;
    if (sel) begin valid_b = 1'b1; q_b.push_back(enc(d, e)); end
    else begin valid_a = 1'b1; q_a.push_back(enc(d, e)); end
    waited = 0;
    o = outs(sel);
    while (!o[2] && waited < 200) begin
      @(negedge clk);
      waited++;
      o = outs(sel);
    end
    if (waited >= 200) chk("accept_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Checks the whole frame clock by clock, starting in the first START clock.
  task automatic frame(input bit sel, input int bc, input logic [10:0] cw, input string tag);
    logic [4:0] o;
    logic etx;
    for (int k = 0; k < 13 * bc; k++) begin
      o = outs(sel);
      if (k < bc) etx = 1'b0;
      else if (k < 12 * bc) etx = cw[(k - bc) / bc];
      else etx = 1'b1;
      chk({tag, "_tx"}, o[4], etx);
      chk({tag, "_frame_done"}, o[1], k == 13 * bc - 1);
      chk({tag, "_busy"}, o[3], 1);
      chk({tag, "_in_ready"}, o[2], 0);
      if (k < 2) chk({tag, "_cw_valid"}, o[0], k == 0);
      @(negedge clk);
    end
    o = outs(sel);
    chk({tag, "_ready_after"}, o[2], 1);
    chk({tag, "_busy_after"}, o[3], 0);
    chk({tag, "_tx_idle"}, o[4], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  d;
    logic [3:0]  e;
    logic [10:0] cw;
  } vec_t;

  initial begin
    int w;
    vec_t tbl[6];
    tbl[0] = '{7'h7F, 4'd0, 11'h7FF};
    tbl[1] = '{7'h01, 4'd0, 11'h007};
    tbl[2] = '{7'h55, 4'd0, 11'h52F};
    tbl[3] = '{7'h55, 4'd5, 11'h53F};
    tbl[4] = '{7'h55, 4'd13, 11'h52F};
    tbl[5] = '{7'h00, 4'd11, 11'h400};

    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; in_data = '0; err_pos = '0;
    #3;
    chk("rst_tx", tx_a, 1);
    chk("rst_in_ready", rdy_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_cw_out", cw_a, 0);
    chk("rst_cw_valid", cwv_a, 0);
    chk("rst_frame_done", fd_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_ready_low", rdy_a, 0);
    @(negedge clk);
    chk("rel_ready_a", rdy_a, 1);
    chk("rel_ready_b", rdy_b, 1);

    // All-zero word: 52-clock frame of start, eleven zeros, stop.
    accept(0, 7'h00, 4'd0, w);
    valid_a = 1'b0;
    chk("zero_cw", cw_a, 11'h000);
    frame(0, 4, 11'h000, "zero");

    // Directed encodings, with and without injection.
    foreach (tbl[i]) begin
      accept(0, tbl[i].d, tbl[i].e, w);
      valid_a = 1'b0;
      chk("vec_cw", cw_a, tbl[i].cw);
      if (tbl[i].e == 4'd5) begin
        chk("dec_syndrome", syndrome(cw_a), 5);
        chk("dec_corrected", correct(cw_a), 7'h55);
      end
      frame(0, 4, tbl[i].cw, "vec");
    end

    // Back-to-back with in_valid held; data changes mid-frame.
    accept(0, 7'h55, 4'd0, w);
    in_data = 7'h2A;
    err_pos = 4'd3;
    frame(0, 4, 11'h52F, "b2b_first");
    accept(0, 7'h2A, 4'd0, w);
    valid_a = 1'b0;
    chk("b2b_wait", w, 0);
    frame(0, 4, enc(7'h2A, 4'd0), "b2b_second");

    // Single-clock bits: idle 1 then 0,1,1,1,0x8,1.
    chk("bc1_idle", tx_b, 1);
    accept(1, 7'h01, 4'd0, w);
    valid_b = 1'b0;
    chk("bc1_cw", cw_b, 11'h007);
    frame(1, 1, 11'h007, "bc1");

    // Reset in the final stop clock: no frame_done, line high, cw cleared.
    accept(0, 7'h7F, 4'd0, w);
    valid_a = 1'b0;
    repeat (51) @(negedge clk);
    chk("pre_rst_frame_done", fd_a, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_ready", rdy_a, 0);
    chk("mid_rst_frame_done", fd_a, 0);
    chk("mid_rst_cw_out", cw_a, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rel_ready_low", rdy_a, 0);
    @(negedge clk);
    chk("mid_rel_ready", rdy_a, 1);
    chk("mid_rel_tx", tx_a, 1);

    // Reset mid-DATA while the line is low.
    accept(0, 7'h00, 4'd0, w);
    valid_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("data_pre_rst_tx", tx_a, 0);
    rst = 1'b1;
    #1 chk("data_rst_tx", tx_a, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("sb_a_drained", q_a.size(), 0);
    chk("sb_b_drained", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
